// File: rtl/fetch_sequencer.sv
// Purpose: program counter and fetch controller; drives the ROM address and issues instructions to execute.
// Latency: one cycle from linenumber to instr; one instruction per cycle while running with instr_ready high.
// Backpressure: instr/pc hold while instr_valid & !instr_ready; linenumber does not advance until the handshake.
module fetch_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int RESET_PC  = 0,
    parameter int LAST_ADDR = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] linenumber,
    input  logic [7:0]        rom_data,
    output logic [7:0]        instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_PC);

    state_t state;
    logic   single_step;
    logic   step_q;
    logic   step_rise;

    // Sequential address with wrap from the last valid ROM line back to 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_A) ? '0 : a + 1'b1;
    endfunction

    // A step held for several cycles must fetch only once, even when execute
    // accepts immediately and the block is back in IDLE before step drops,
    // so only the rising edge of step starts a single-step fetch.
    assign step_rise = step & ~step_q;

    // Fetch FSM: redirect/halt first, then idle start or issue handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            linenumber  <= RESET_A;
            instr       <= 8'h00;
            pc          <= RESET_A;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            single_step <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            step_q <= step;
            if (state == HALT) begin
                // Frozen until reset.
                instr_valid <= 1'b0;
                halted      <= 1'b1;
            end else if (redirect_valid) begin
                // Pending instruction is discarded; a same-cycle handshake
                // has already consumed it, and no new fetch is started.
                instr_valid <= 1'b0;
                single_step <= 1'b0;
                if (redirect_target <= LAST_A) begin
                    linenumber <= redirect_target;
                    state      <= IDLE;
                end else begin
                    halted <= 1'b1;
                    state  <= HALT;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (run || step_rise) begin
                            instr       <= rom_data;
                            pc          <= linenumber;
                            instr_valid <= 1'b1;
                            linenumber  <= next_addr(linenumber);
                            single_step <= ~run;
                            state       <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (instr_ready) begin
                            if (run && !single_step) begin
                                instr       <= rom_data;
                                pc          <= linenumber;
                                instr_valid <= 1'b1;
                                linenumber  <= next_addr(linenumber);
                            end else begin
                                instr_valid <= 1'b0;
                                single_step <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
